// File: rtl/rc4_pkg.sv
// RC4 sequencer shared definitions.
// State codes, S-box geometry and per-phase cycle counts.
package rc4_pkg;

  localparam int SBOX_SIZE      = 256;
  localparam int SBOX_AW        = 8;
  localparam int INIT_CYC       = 256;
  localparam int KSA_CYC_PER_I  = 5;
  localparam int PRGA_CYC_PER_B = 7;

  typedef logic [3:0] state_t;

  localparam state_t IDLE = 4'd0;
  localparam state_t INIT = 4'd1;
  localparam state_t K_RI = 4'd2;
  localparam state_t K_CJ = 4'd3;
  localparam state_t K_RJ = 4'd4;
  localparam state_t K_WI = 4'd5;
  localparam state_t K_WJ = 4'd6;
  localparam state_t P_RI = 4'd7;
  localparam state_t P_CJ = 4'd8;
  localparam state_t P_RJ = 4'd9;
  localparam state_t P_WI = 4'd10;
  localparam state_t P_WJ = 4'd11;
  localparam state_t P_RK = 4'd12;
  localparam state_t P_XK = 4'd13;
  localparam state_t DONE = 4'd14;

  function automatic int op_cycles(int mb);
    return 1 + INIT_CYC
         + SBOX_SIZE * KSA_CYC_PER_I
         + PRGA_CYC_PER_B * mb;
  endfunction

endpackage

// File: rtl/rc4_seq_ctrl_if.sv
// RC4 sequencer host handshake and S-box RAM bus.
// master = host, slave = controller, ram = S-box.
interface rc4_seq_ctrl_if
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 5,
  parameter int MSG_BYTES = 5
);

  logic                   start;
  logic [8*KEY_BYTES-1:0] key;
  logic [8*MSG_BYTES-1:0] ptext;
  logic                   busy;
  logic                   done;
  logic [8*MSG_BYTES-1:0] ctext;
  logic [SBOX_AW-1:0]     sb_addr;
  logic [7:0]             sb_wdata;
  logic                   sb_we;
  logic [7:0]             sb_rdata;

  modport master (
    output start, key, ptext,
    input  busy, done, ctext
  );

  modport slave (
    input  start, key, ptext, sb_rdata,
    output busy, done, ctext,
    output sb_addr, sb_wdata, sb_we
  );

  modport ram (
    input  sb_addr, sb_wdata, sb_we,
    output sb_rdata
  );

endinterface

// File: rtl/rc4_sbox_ram.sv
// 256x8 synchronous single-port S-box RAM.
// Read data appears the cycle after the address.
module rc4_sbox_ram
  import rc4_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [SBOX_AW-1:0] addr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata
);

  logic [7:0] mem [SBOX_SIZE];

  // write port plus registered read
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/rc4_seq_ctrl.sv
// RC4 sequencer: S-box init, KSA and PRGA over
// one external single-port RAM, start/busy/done.
module rc4_seq_ctrl
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 5,
  parameter int MSG_BYTES = 5
)(
  input  logic            clk,
  input  logic            rst,
  rc4_seq_ctrl_if.slave   bus
);

  localparam int KW = 8 * KEY_BYTES;
  localparam int MW = 8 * MSG_BYTES;
  localparam logic [7:0] LAST_I = 8'(SBOX_SIZE - 1);
  localparam logic [5:0] LAST_N = 6'(MSG_BYTES - 1);

  state_t        state;
  logic [7:0]    i, j, si, sj;
  logic [5:0]    n;
  logic [KW-1:0] key_q, key_rot;
  logic [MW-1:0] pt_q, pt_sh;
  logic [MW-1:0] ct_q, ct_sh;
  logic [7:0]    kbyte, xbyte;

  // key rotates so its top byte is always key[i mod KEY_BYTES]
  assign kbyte = key_q[KW-1 -: 8];
  assign xbyte = pt_q[MW-1 -: 8] ^ bus.sb_rdata;

  if (KEY_BYTES > 1) begin : g_krot
    assign key_rot = {key_q[KW-9:0], kbyte};
  end else begin : g_kone
    assign key_rot = key_q;
  end

  if (MSG_BYTES > 1) begin : g_msh
    assign pt_sh = {pt_q[MW-9:0], 8'h00};
    assign ct_sh = {ct_q[MW-9:0], xbyte};
  end else begin : g_mone
    assign pt_sh = '0;
    assign ct_sh = xbyte;
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign bus.ctext = ct_q;

  // RAM address/data/strobe decoded from state
  always_comb begin
    bus.sb_we    = 1'b0;
    bus.sb_addr  = '0;
    bus.sb_wdata = '0;
    case (state)
      INIT: begin
        bus.sb_we    = 1'b1;
        bus.sb_addr  = i;
        bus.sb_wdata = i;
      end
      K_RI: bus.sb_addr = i;
      K_RJ: bus.sb_addr = j;
      K_WI, P_WI: begin
        bus.sb_we    = 1'b1;
        bus.sb_addr  = i;
        bus.sb_wdata = bus.sb_rdata;
      end
      K_WJ, P_WJ: begin
        bus.sb_we    = 1'b1;
        bus.sb_addr  = j;
        bus.sb_wdata = si;
      end
      P_RI: bus.sb_addr = i + 8'd1;
      P_RJ: bus.sb_addr = j;
      P_RK: bus.sb_addr = si + sj;
      default: ;
    endcase
  end

  // sequencer state, indices and data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      si    <= '0;
      sj    <= '0;
      n     <= '0;
      key_q <= '0;
      pt_q  <= '0;
      ct_q  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          key_q <= bus.key;
          pt_q  <= bus.ptext;
          i     <= '0;
          j     <= '0;
          n     <= '0;
          state <= INIT;
        end
        INIT: begin
          i <= i + 8'd1;
          if (i == LAST_I) begin
            j     <= '0;
            state <= K_RI;
          end
        end
        K_RI: state <= K_CJ;
        K_CJ: begin
          si    <= bus.sb_rdata;
          j     <= j + bus.sb_rdata + kbyte;
          state <= K_RJ;
        end
        K_RJ: state <= K_WI;
        K_WI: begin
          sj    <= bus.sb_rdata;
          state <= K_WJ;
        end
        K_WJ: begin
          i     <= i + 8'd1;
          key_q <= key_rot;
          if (i == LAST_I) begin
            j     <= '0;
            state <= P_RI;
          end else begin
            state <= K_RI;
          end
        end
        P_RI: begin
          i     <= i + 8'd1;
          state <= P_CJ;
        end
        P_CJ: begin
          si    <= bus.sb_rdata;
          j     <= j + bus.sb_rdata;
          state <= P_RJ;
        end
        P_RJ: state <= P_WI;
        P_WI: begin
          sj    <= bus.sb_rdata;
          state <= P_WJ;
        end
        P_WJ: state <= P_RK;
        P_RK: state <= P_XK;
        P_XK: begin
          ct_q <= ct_sh;
          pt_q <= pt_sh;
          n    <= n + 6'd1;
          state <= (n == LAST_N) ? DONE : P_RI;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
